// File: rtl/seg_access_ctrl_pkg.sv
// Purpose: shared types and constants for the segment access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: segment codes, FSM state enum, physical-address width.
package seg_pkg;

  localparam int PHYS_W = 20;

  localparam logic [1:0] SEG_ES = 2'b00;
  localparam logic [1:0] SEG_CS = 2'b01;
  localparam logic [1:0] SEG_SS = 2'b10;
  localparam logic [1:0] SEG_DS = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CALC  = 3'd3,
    ST_DONE  = 3'd4
  } seg_state_t;

endpackage

// File: rtl/seg_access_ctrl_if.sv
// Purpose: request/ack bundle between decoder/execute and the segment access controller.
// Latency: n/a (wires only).
// Backpressure: each req is held by the master until its one-cycle ack pulse.
// Modports: master = decoder/execute side (drives requests), slave = controller (drives acks).
interface seg_access_ctrl_if #(
  parameter int SEG_W = 16
);
  logic             fetch_req;
  logic [SEG_W-1:0] fetch_off;
  logic             fetch_ack;
  logic             data_req;
  logic [SEG_W-1:0] data_off;
  logic [1:0]       data_seg;
  logic             data_no_ovr;
  logic             data_ack;
  logic             ovr_valid;
  logic [1:0]       ovr_seg;
  logic             wr_req;
  logic [1:0]       wr_sel;
  logic [SEG_W-1:0] wr_data;
  logic             wr_ack;

  modport master (
    output fetch_req, fetch_off, data_req, data_off, data_seg, data_no_ovr,
           ovr_valid, ovr_seg, wr_req, wr_sel, wr_data,
    input  fetch_ack, data_ack, wr_ack
  );

  modport slave (
    input  fetch_req, fetch_off, data_req, data_off, data_seg, data_no_ovr,
           ovr_valid, ovr_seg, wr_req, wr_sel, wr_data,
    output fetch_ack, data_ack, wr_ack
  );

endinterface

// File: rtl/seg_access_ctrl_arbiter.sv
// Purpose: fetch/data priority arbiter with a starvation guard for fetch.
// Latency: grant is combinational; starvation counter updates on the clock edge.
// Backpressure: grants only while arb_en is high; losers simply stay pending.
// Ports: clk, rst, arb_en, fetch_req, data_req -> grant_fetch, grant_data.
module seg_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic fetch_req,
  input  logic data_req,
  output logic grant_fetch,
  output logic grant_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  // Data normally beats fetch; once fetch has lost STARVE_MAX contested
  // rounds in a row it is given the next contested grant.
  always_comb begin
    grant_fetch = arb_en && fetch_req && (!data_req || starved);
    grant_data  = arb_en && data_req && (!fetch_req || !starved);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_fetch) begin
      starve_cnt <= '0;
    end else if (grant_data && fetch_req && !starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_access_ctrl.sv
// Purpose: sequences segment-register reads/writes and forms 20-bit physical addresses.
// Latency: fetch/data ack 3 cycles after the IDLE grant; write ack 1 cycle after IDLE.
// Backpressure: requests are held until ack; writes pre-empt reads in IDLE, fetch starvation-guarded.
// Ports: clk, rst, bus (seg_access_ctrl_if.slave), register file read/write port,
//        phys_addr, busy.
// Build option: SEG_OVERRIDE_EN builds the segment-override prefix latch; without
//        it ovr_valid/ovr_seg are ignored and data always uses data_seg.
module seg_access_ctrl
  import seg_pkg::*;
#(
  parameter int SEG_W      = 16,
  parameter int ADDR_W     = PHYS_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  seg_access_ctrl_if.slave  bus,
  output logic [1:0]        seg_rd_sel,
  input  logic [SEG_W-1:0]  seg_rd_data,
  output logic              seg_wr_en,
  output logic [1:0]        seg_wr_sel,
  output logic [SEG_W-1:0]  seg_wr_data,
  output logic [ADDR_W-1:0] phys_addr,
  output logic              busy
);

  seg_state_t       state_q, state_d;
  logic             win_data_q;
  logic [SEG_W-1:0] off_q;
  logic             arb_en;
  logic             grant_fetch, grant_data;
  logic [1:0]       data_rd_seg;
  logic [ADDR_W-1:0] calc_addr;

  // Pending writes are served ahead of any read request.
  assign arb_en = (state_q == ST_IDLE) && !bus.wr_req;

  seg_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .arb_en      (arb_en),
    .fetch_req   (bus.fetch_req),
    .data_req    (bus.data_req),
    .grant_fetch (grant_fetch),
    .grant_data  (grant_data)
  );

`ifdef SEG_OVERRIDE_EN
  logic       ovr_vld_q;
  logic [1:0] ovr_seg_q;

  // A new prefix always wins over the clear so a prefix decoded during the
  // closing cycle of a data access is kept for the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_vld_q <= 1'b0;
      ovr_seg_q <= 2'b00;
    end else if (bus.ovr_valid) begin
      ovr_vld_q <= 1'b1;
      ovr_seg_q <= bus.ovr_seg;
    end else if (state_q == ST_DONE && win_data_q) begin
      ovr_vld_q <= 1'b0;
    end
  end

  // Uses the registered latch, so a prefix arriving during READ is not
  // applied to the access already in READ.
  always_comb begin
    data_rd_seg = bus.data_seg;
    if (ovr_vld_q && !bus.data_no_ovr) begin
      data_rd_seg = ovr_seg_q;
    end
  end
`else
  logic unused_ovr;
  assign unused_ovr  = ^{bus.ovr_valid, bus.ovr_seg};
  assign data_rd_seg = bus.data_seg;
`endif

  // Offset is zero-extended; the carry out of the top bit is dropped so the
  // address wraps within the physical space.
  assign calc_addr = {seg_rd_data, 4'b0000} + ADDR_W'(off_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.wr_req) begin
          state_d = ST_WRITE;
        end else if (grant_fetch || grant_data) begin
          state_d = ST_READ;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ:  state_d = ST_CALC;
      ST_CALC:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Winner/offset capture and the address register
  always_ff @(posedge clk) begin
    if (rst) begin
      win_data_q <= 1'b0;
      off_q      <= '0;
      phys_addr  <= '0;
    end else begin
      if (grant_fetch) begin
        win_data_q <= 1'b0;
        off_q      <= bus.fetch_off;
      end else if (grant_data) begin
        win_data_q <= 1'b1;
        off_q      <= bus.data_off;
      end
      if (state_q == ST_CALC) begin
        phys_addr <= calc_addr;
      end
    end
  end

  // Output logic; everything is forced quiet during the reset cycle so an
  // interrupted write or access never leaks an enable or ack.
  always_comb begin
    seg_rd_sel    = 2'b00;
    seg_wr_en     = 1'b0;
    seg_wr_sel    = 2'b00;
    seg_wr_data   = '0;
    bus.fetch_ack = 1'b0;
    bus.data_ack  = 1'b0;
    bus.wr_ack    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_WRITE: begin
          seg_wr_en   = 1'b1;
          seg_wr_sel  = bus.wr_sel;
          seg_wr_data = bus.wr_data;
          bus.wr_ack  = 1'b1;
        end
        ST_READ: begin
          seg_rd_sel = win_data_q ? data_rd_seg : SEG_CS;
        end
        ST_DONE: begin
          bus.fetch_ack = !win_data_q;
          bus.data_ack  = win_data_q;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);

  // Requests must stay asserted until their ack has been seen.
  a_hold_wr: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_WRITE) |-> bus.wr_req);
  a_hold_fetch: assert property (@(posedge clk) disable iff (rst)
    (state_q inside {ST_READ, ST_CALC, ST_DONE} && !win_data_q) |-> bus.fetch_req);
  a_hold_data: assert property (@(posedge clk) disable iff (rst)
    (state_q inside {ST_READ, ST_CALC, ST_DONE} && win_data_q) |-> bus.data_req);

endmodule

// File: tb/tb_seg_access_ctrl.sv
// Purpose: randomized + directed scoreboard bench for seg_access_ctrl.
// Latency: n/a.
// Backpressure: requesters hold req until ack, then load the next queued item.
module tb_seg_access_ctrl;
  import seg_pkg::*;

  localparam int STARVE = 3;
  localparam int K_FETCH = 0, K_DATA = 1, K_WR = 2;
  localparam int BOUND = 300;

  typedef struct { int kind; logic [19:0] addr; } exp_t;
  typedef struct { logic [15:0] off; logic [1:0] seg; logic no_ovr; } dreq_t;
  typedef struct { logic [1:0] sel; logic [15:0] val; } wreq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  seg_rd_sel;
  logic [15:0] seg_rd_data;
  logic        seg_wr_en;
  logic [1:0]  seg_wr_sel;
  logic [15:0] seg_wr_data;
  logic [19:0] phys_addr;
  logic        busy;

  seg_access_ctrl_if #(.SEG_W(16)) bus ();

  seg_access_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .seg_rd_sel  (seg_rd_sel),
    .seg_rd_data (seg_rd_data),
    .seg_wr_en   (seg_wr_en),
    .seg_wr_sel  (seg_wr_sel),
    .seg_wr_data (seg_wr_data),
    .phys_addr   (phys_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Register file environment: registered read, 1-cycle latency.
  logic [15:0] rf [4];
  always @(posedge clk) begin
    if (seg_wr_en) rf[seg_wr_sel] <= seg_wr_data;
    seg_rd_data <= rf[seg_rd_sel];
  end

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic fail_msg(string name);
    n_checks++;
    $display("FAIL %s: got no/extra event, expected ordered ack", name);
  endtask

  // Monitor: pops one expectation per ack.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (!rst && (bus.fetch_ack || bus.data_ack || bus.wr_ack)) begin
      k = bus.wr_ack ? K_WR : (bus.data_ack ? K_DATA : K_FETCH);
      chk("single_ack", 32'(bus.fetch_ack) + 32'(bus.data_ack) + 32'(bus.wr_ack), 1);
      if (exp_q.size() == 0) begin
        fail_msg("unexpected_ack");
      end else begin
        e = exp_q.pop_front();
        chk("ack_kind", k, e.kind);
        if (e.kind != K_WR) chk("phys_addr", phys_addr, e.addr);
      end
    end
  end

  // Reference model state
  int         m_seg [4];
  int         m_starve = 0;
  bit         m_ovr_vld = 0;
  logic [1:0] m_ovr_seg = 2'b00;

  logic [15:0] f_in[$];
  dreq_t       d_in[$];
  wreq_t       w_in[$];
  int fetch_lat, data_lat, wr_lat;

  function automatic logic [19:0] addr_of(int segv, int off);
    int a;
    a = segv * 16 + off;
    return 20'(a % (1 << 20));
  endfunction

  // Service order follows from the rules: all writes first, then reads with
  // data preferred unless fetch has lost STARVE contested rounds.
  task automatic predict();
    int i_f, i_d;
    bit pick_data;
    logic [1:0] s;
    foreach (w_in[i]) begin
      exp_q.push_back('{K_WR, 20'h0});
      m_seg[w_in[i].sel] = int'(w_in[i].val);
    end
    i_f = 0; i_d = 0;
    while (i_f < f_in.size() || i_d < d_in.size()) begin
      if (i_f < f_in.size() && i_d < d_in.size()) pick_data = (m_starve != STARVE);
      else pick_data = (i_d < d_in.size());
      if (pick_data) begin
        s = d_in[i_d].seg;
`ifdef SEG_OVERRIDE_EN
        if (m_ovr_vld && !d_in[i_d].no_ovr) s = m_ovr_seg;
        m_ovr_vld = 0;
`endif
        if (i_f < f_in.size() && m_starve < STARVE) m_starve++;
        exp_q.push_back('{K_DATA, addr_of(m_seg[s], int'(d_in[i_d].off))});
        i_d++;
      end else begin
        m_starve = 0;
        exp_q.push_back('{K_FETCH, addr_of(m_seg[SEG_CS], int'(f_in[i_f]))});
        i_f++;
      end
    end
  endtask

  task automatic run_fetch();
    int cyc;
    while (f_in.size() > 0) begin
      bus.fetch_off = f_in.pop_front();
      bus.fetch_req = 1'b1;
      cyc = 0;
      while (cyc < BOUND) begin @(negedge clk); if (bus.fetch_ack) break; cyc++; end
      fetch_lat = cyc;
      if (cyc >= BOUND) fail_msg("fetch_ack_timeout");
      @(posedge clk); #1;
      bus.fetch_req = 1'b0;
    end
  endtask

  task automatic run_data();
    int cyc;
    dreq_t d;
    while (d_in.size() > 0) begin
      d = d_in.pop_front();
      bus.data_off = d.off; bus.data_seg = d.seg; bus.data_no_ovr = d.no_ovr;
      bus.data_req = 1'b1;
      cyc = 0;
      while (cyc < BOUND) begin @(negedge clk); if (bus.data_ack) break; cyc++; end
      data_lat = cyc;
      if (cyc >= BOUND) fail_msg("data_ack_timeout");
      @(posedge clk); #1;
      bus.data_req = 1'b0;
    end
  endtask

  task automatic run_wr();
    int cyc;
    wreq_t w;
    while (w_in.size() > 0) begin
      w = w_in.pop_front();
      bus.wr_sel = w.sel; bus.wr_data = w.val;
      bus.wr_req = 1'b1;
      cyc = 0;
      while (cyc < BOUND) begin @(negedge clk); if (bus.wr_ack) break; cyc++; end
      wr_lat = cyc;
      if (cyc >= BOUND) fail_msg("wr_ack_timeout");
      @(posedge clk); #1;
      bus.wr_req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < BOUND) begin @(posedge clk); #1; cyc++; end
    if (cyc >= BOUND) fail_msg("idle_timeout");
  endtask

  task automatic run_round(bit do_ovr, logic [1:0] ovr_s);
    wait_idle();
    if (do_ovr) begin
      bus.ovr_valid = 1'b1; bus.ovr_seg = ovr_s;
      @(posedge clk); #1;
      bus.ovr_valid = 1'b0;
      m_ovr_vld = 1; m_ovr_seg = ovr_s;
    end
    predict();
    fork
      run_wr();
      run_fetch();
      run_data();
    join
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, nf, nd;
    foreach (rf[i]) rf[i] = 16'h0;
    foreach (m_seg[i]) m_seg[i] = 0;
    rst = 1'b1;
    bus.fetch_req = 0; bus.fetch_off = 0; bus.data_req = 0; bus.data_off = 0;
    bus.data_seg = 0; bus.data_no_ovr = 0; bus.ovr_valid = 0; bus.ovr_seg = 0;
    bus.wr_req = 0; bus.wr_sel = 0; bus.wr_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fetch_ack", bus.fetch_ack, 0);
    chk("rst_data_ack", bus.data_ack, 0);
    chk("rst_wr_ack", bus.wr_ack, 0);
    chk("rst_seg_wr_en", seg_wr_en, 0);
    chk("rst_seg_rd_sel", seg_rd_sel, 0);
    chk("rst_phys_addr", phys_addr, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Register setup, also checks write latency.
    w_in.push_back('{SEG_CS, 16'hF000});
    w_in.push_back('{SEG_DS, 16'hFFFF});
    w_in.push_back('{SEG_ES, 16'h1000});
    run_round(0, 2'b00);
    chk("wr_latency", wr_lat, 1);

    // Fetch only: 0xF000:0xFFF0.
    f_in.push_back(16'hFFF0);
    run_round(0, 2'b00);
    chk("fetch_latency", fetch_lat, 3);

    // Wrap-around through DS.
    d_in.push_back('{16'h0020, SEG_DS, 1'b0});
    run_round(0, 2'b00);
    chk("data_latency", data_lat, 3);

    // Override to ES, then an unprefixed access back on DS.
    d_in.push_back('{16'h0004, SEG_DS, 1'b0});
    d_in.push_back('{16'h0004, SEG_DS, 1'b0});
    run_round(1, SEG_ES);

    // Override suppressed by data_no_ovr; latch still consumed.
    d_in.push_back('{16'h0008, SEG_ES, 1'b1});
    d_in.push_back('{16'h0008, SEG_DS, 1'b0});
    run_round(1, SEG_SS);

    // Contention with both held: starvation guard lets fetch through.
    repeat (2) f_in.push_back(16'h0100);
    repeat (5) d_in.push_back('{16'h0200, SEG_DS, 1'b0});
    run_round(0, 2'b00);

    // Write wins over a same-cycle read of the same segment.
    w_in.push_back('{SEG_SS, 16'h2345});
    d_in.push_back('{16'h0000, SEG_SS, 1'b0});
    run_round(0, 2'b00);

    // Reset while in CALC: no ack, idle right after.
    wait_idle();
    bus.data_off = 16'h0010; bus.data_seg = SEG_DS; bus.data_no_ovr = 0;
    bus.data_req = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("busy_in_calc", busy, 1);
    rst = 1'b1; bus.data_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_starve = 0; m_ovr_vld = 0;
    @(negedge clk);
    chk("busy_after_rst", busy, 0);
    chk("no_ack_after_rst", 32'(bus.data_ack) + 32'(bus.fetch_ack), 0);
    repeat (4) @(posedge clk);
    #1;

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      nw = $urandom_range(0, 2);
      nf = (r % 8 == 7) ? 2 : $urandom_range(0, 2);
      nd = (r % 8 == 7) ? 6 : $urandom_range(0, 3);
      for (int i = 0; i < nw; i++)
        w_in.push_back('{2'($urandom_range(0, 3)), 16'($urandom)});
      for (int i = 0; i < nf; i++) f_in.push_back(16'($urandom));
      for (int i = 0; i < nd; i++)
        d_in.push_back('{16'($urandom), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 3) == 0)});
      run_round(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
